// File: rtl/pll_phase_shift_controller_pkg.sv
// rtl/pll_phase_shift_controller_pkg.sv - constants shared by the UART data mapper and the PLL phase-shift sequencer
package pll_phase_shift_controller_pkg;

    localparam logic [2:0] INIT_COUNTER = 3'b110;

    localparam logic PLL_SEL_1 = 1'b0;
    localparam logic PLL_SEL_2 = 1'b1;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_STEP      = 3'd1;
    localparam logic [2:0] ST_WAIT_LOW  = 3'd2;
    localparam logic [2:0] ST_WAIT_HIGH = 3'd3;
    localparam logic [2:0] ST_GAP       = 3'd4;
    localparam logic [2:0] ST_DONE      = 3'd5;

    function automatic logic pick_pll(input logic sel, input logic pll_1_val, input logic pll_2_val);
        return (sel == PLL_SEL_2) ? pll_2_val : pll_1_val;
    endfunction

endpackage

// File: rtl/pll_phase_shift_controller_step.sv
// rtl/pll_phase_shift_controller_step.sv - one phasestep/phasedone handshake with per-edge timeout
module pll_phase_step
    import pll_phase_shift_controller_pkg::*;
#(
    parameter int STEP_HIGH_CYCLES = 2,
    parameter int DONE_TIMEOUT     = 255
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_start,
    input  logic i_phasedone,
    output logic o_phasestep,
    output logic o_done,
    output logic o_timeout
);

    localparam int TMR_W_RAW = $clog2(DONE_TIMEOUT + 1);
    localparam int TMR_W     = (TMR_W_RAW < 8) ? 8 : TMR_W_RAW;

    localparam logic [TMR_W-1:0] HOLD_LAST = TMR_W'(STEP_HIGH_CYCLES - 1);
    localparam logic [TMR_W-1:0] TMO_LAST  = TMR_W'(DONE_TIMEOUT - 1);

    logic [2:0]       state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             phasestep_q, phasestep_d;

    // One timer serves both the step-high hold and the two phasedone waits.
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        phasestep_d = phasestep_q;
        o_done      = 1'b0;
        o_timeout   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    state_d     = ST_STEP;
                    timer_d     = '0;
                    phasestep_d = 1'b1;
                end
            end
            ST_STEP: begin
                if (timer_q == HOLD_LAST) begin
                    state_d     = ST_WAIT_LOW;
                    timer_d     = '0;
                    phasestep_d = 1'b0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_WAIT_LOW: begin
                if (!i_phasedone) begin
                    state_d = ST_WAIT_HIGH;
                    timer_d = '0;
                end else if (timer_q == TMO_LAST) begin
                    o_timeout   = 1'b1;
                    state_d     = ST_IDLE;
                    phasestep_d = 1'b0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_WAIT_HIGH: begin
                if (i_phasedone) begin
                    o_done  = 1'b1;
                    state_d = ST_IDLE;
                end else if (timer_q == TMO_LAST) begin
                    o_timeout   = 1'b1;
                    state_d     = ST_IDLE;
                    phasestep_d = 1'b0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                phasestep_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= ST_IDLE;
            timer_q     <= '0;
            phasestep_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            phasestep_q <= phasestep_d;
        end
    end

    assign o_phasestep = phasestep_q;

endmodule

// File: rtl/pll_phase_shift_controller.sv
// rtl/pll_phase_shift_controller.sv - sequences multi-step dynamic phase shifts on two PLLs
module pll_phase_shift_controller
    import pll_phase_shift_controller_pkg::*;
#(
    parameter int STEP_HIGH_CYCLES = 2,
    parameter int DONE_TIMEOUT     = 255
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_shift_ready,
    input  logic [7:0] i_periods_to_process,
    input  logic [2:0] i_phasecounterselect_1,
    input  logic [2:0] i_phasecounterselect_2,
    input  logic       i_pll_to_update,
    input  logic       i_phaseupdown,
    input  logic       i_phasedone_1,
    input  logic       i_phasedone_2,
    output logic       o_phasestep_1,
    output logic       o_phasestep_2,
    output logic [2:0] o_phasecounterselect_1,
    output logic [2:0] o_phasecounterselect_2,
    output logic       o_phaseupdown,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_error,
    output logic       o_dropped,
    output logic [7:0] o_steps_done
);

    logic [2:0] state_q, state_d;
    logic       strobe_prev_q;
    logic       pll_q, pll_d;
    logic [7:0] target_q, target_d;
    logic [7:0] steps_q, steps_d;
    logic [2:0] sel_1_q, sel_1_d;
    logic [2:0] sel_2_q, sel_2_d;
    logic       updown_q, updown_d;
    logic       error_q, error_d;
    logic       dropped_q, dropped_d;

    logic       strobe_edge;
    logic       step_start;
    logic       step_done;
    logic       step_timeout;
    logic       step_pulse;
    logic [7:0] steps_inc;

    assign strobe_edge = i_shift_ready & ~strobe_prev_q;
    assign step_start  = (state_q == ST_GAP) && (steps_q != target_q);
    assign steps_inc   = steps_q + 8'd1;

    pll_phase_step #(
        .STEP_HIGH_CYCLES (STEP_HIGH_CYCLES),
        .DONE_TIMEOUT     (DONE_TIMEOUT)
    ) u_step (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_start     (step_start),
        .i_phasedone (pick_pll(pll_q, i_phasedone_1, i_phasedone_2)),
        .o_phasestep (step_pulse),
        .o_done      (step_done),
        .o_timeout   (step_timeout)
    );

    // Acceptance passes through GAP so select/direction settle a cycle before the first phasestep.
    always_comb begin
        state_d   = state_q;
        pll_d     = pll_q;
        target_d  = target_q;
        steps_d   = steps_q;
        sel_1_d   = sel_1_q;
        sel_2_d   = sel_2_q;
        updown_d  = updown_q;
        error_d   = error_q;
        dropped_d = strobe_edge && (state_q != ST_IDLE);
        case (state_q)
            ST_IDLE: begin
                if (strobe_edge) begin
                    pll_d    = i_pll_to_update;
                    target_d = i_periods_to_process;
                    sel_1_d  = i_phasecounterselect_1;
                    sel_2_d  = i_phasecounterselect_2;
                    updown_d = i_phaseupdown;
                    error_d  = 1'b0;
                    steps_d  = 8'd0;
                    state_d  = ST_GAP;
                end
            end
            ST_GAP: begin
                state_d = (steps_q == target_q) ? ST_DONE : ST_STEP;
            end
            ST_STEP: begin
                if (step_done) begin
                    steps_d = steps_inc;
                    state_d = (steps_inc == target_q) ? ST_DONE : ST_GAP;
                end else if (step_timeout) begin
                    error_d = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q       <= ST_IDLE;
            strobe_prev_q <= 1'b0;
            pll_q         <= PLL_SEL_1;
            target_q      <= 8'd0;
            steps_q       <= 8'd0;
            sel_1_q       <= INIT_COUNTER;
            sel_2_q       <= INIT_COUNTER;
            updown_q      <= 1'b0;
            error_q       <= 1'b0;
            dropped_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            strobe_prev_q <= i_shift_ready;
            pll_q         <= pll_d;
            target_q      <= target_d;
            steps_q       <= steps_d;
            sel_1_q       <= sel_1_d;
            sel_2_q       <= sel_2_d;
            updown_q      <= updown_d;
            error_q       <= error_d;
            dropped_q     <= dropped_d;
        end
    end

    assign o_phasestep_1          = step_pulse && (pll_q == PLL_SEL_1);
    assign o_phasestep_2          = step_pulse && (pll_q == PLL_SEL_2);
    assign o_phasecounterselect_1 = sel_1_q;
    assign o_phasecounterselect_2 = sel_2_q;
    assign o_phaseupdown          = updown_q;
    assign o_busy                 = (state_q != ST_IDLE);
    assign o_done                 = (state_q == ST_DONE);
    assign o_error                = error_q;
    assign o_dropped              = dropped_q;
    assign o_steps_done           = steps_q;

endmodule
